// File: rtl/de0qsys_sw_pkg.sv
// Shared definitions for the slide-switch debounce controller: Avalon word
// addresses of the register map and the per-bit debounce FSM state encoding.
package de0qsys_sw_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_RAW  = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit debouncer: accepts a new synchronised level only after it holds
// for DEBOUNCE_CYCLES consecutive cycles in CHANGING.
// Ports: clk_i, reset_i (sync, active-high), sync_i (synchronised level),
//        deb_o (debounced level).
module sw_debounce_bit
    import de0qsys_sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sync_i,
    output logic deb_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        unique case (state_q)
            STABLE: begin
                if (sync_i != deb_q) begin
                    state_d = CHANGING;
                    cnt_d   = '0;
                end
            end
            CHANGING: begin
                // A return to the old level at any point rejects the glitch.
                if (sync_i == deb_q) begin
                    state_d = STABLE;
                end else if (cnt_q == CNT_MAX) begin
                    deb_d   = sync_i;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = STABLE;
        endcase
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/de0qsys_sw_debounce_ctrl.sv
// Avalon-MM slave for the board slide switches: 2-FF sync, per-bit debounce,
// edge capture with W1C clear and a maskable level irq.
// Ports: clk, reset (sync, active-high), in_port (raw switches), address,
//        chipselect, write, writedata, readdata (1-cycle latency), irq.
// Build option: define SW_EDGE_IRQ_EN to implement edgecapture/irqmask/irq;
// otherwise addr 1/3 read 0, writes are ignored and irq is tied low.
module de0qsys_sw_debounce_ctrl
    import de0qsys_sw_pkg::*;
#(
    parameter  int WIDTH           = 4,
    parameter  int DEBOUNCE_CYCLES = 50000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] mask_rd, edge_rd;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_ok;

    assign wr_en     = chipselect & write;
    assign unused_ok = ^{wr_en, writedata};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= in_port;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk_i   (clk),
            .reset_i (reset),
            .sync_i  (s2_q[i]),
            .deb_o   (deb[i])
        );
    end

`ifdef SW_EDGE_IRQ_EN
    logic [WIDTH-1:0] deb_dly_q;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_dly_q <= '0;
            edge_q    <= '0;
            mask_q    <= '0;
        end else begin
            deb_dly_q <= deb;
            edge_q    <= edge_d;
            mask_q    <= mask_d;
        end
    end

    always_comb begin
        edge_d = edge_q;
        mask_d = mask_q;
        if (wr_en && address == ADDR_EDGE) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        // Applied after the clear so a coincident new edge is never lost.
        edge_d = edge_d | (deb ^ deb_dly_q);
        if (wr_en && address == ADDR_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
    end

    assign mask_rd = mask_q;
    assign edge_rd = edge_q;
    assign irq     = |(edge_q & mask_q);
`else
    assign mask_rd = '0;
    assign edge_rd = '0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        readdata_d = '0;
        unique case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = deb;
            ADDR_MASK: readdata_d[WIDTH-1:0] = mask_rd;
            ADDR_RAW:  readdata_d[WIDTH-1:0] = s2_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_rd;
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule
